// File: rtl/imem_load_arb_if.sv
// Port bundle for the instruction-SRAM arbiter: fetch, loader stream and SRAM sides.
// The slave modport is the arbiter; the master modport is its environment.
`timescale 1ns/1ps
interface imem_load_arb_if #(
    parameter int AW = 10
);
    logic          fet_req_i;
    logic [31:0]   fet_addr_i;
    logic          fet_gnt_o;
    logic          fet_rvalid_o;
    logic [31:0]   fet_instr_o;
    logic          fet_misalign_o;

    logic          ld_start_i;
    logic          ld_valid_i;
    logic          ld_ready_o;
    logic [31:0]   ld_data_i;
    logic          ld_last_i;
    logic [AW:0]   ld_count_o;
    logic          ld_err_o;

    logic          core_hold_o;

    logic          mem_en_o;
    logic          mem_we_o;
    logic [AW-1:0] mem_addr_o;
    logic [31:0]   mem_wdata_o;
    logic [31:0]   mem_rdata_i;

    modport slave (
        input  fet_req_i, fet_addr_i, ld_start_i, ld_valid_i, ld_data_i, ld_last_i,
               mem_rdata_i,
        output fet_gnt_o, fet_rvalid_o, fet_instr_o, fet_misalign_o, ld_ready_o,
               ld_count_o, ld_err_o, core_hold_o, mem_en_o, mem_we_o, mem_addr_o,
               mem_wdata_o
    );

    modport master (
        output fet_req_i, fet_addr_i, ld_start_i, ld_valid_i, ld_data_i, ld_last_i,
               mem_rdata_i,
        input  fet_gnt_o, fet_rvalid_o, fet_instr_o, fet_misalign_o, ld_ready_o,
               ld_count_o, ld_err_o, core_hold_o, mem_en_o, mem_we_o, mem_addr_o,
               mem_wdata_o
    );
endinterface

// File: rtl/imem_load_arb.sv
// Single-port instruction SRAM arbiter: boot/reload stream writes consecutive words
// while the core is held, then the port serves one fetch per cycle with latency 1.
`timescale 1ns/1ps
module imem_load_arb #(
    parameter int          AW          = 10,
    parameter logic [31:0] RESET_INSTR = 32'h0000_0013
) (
    input  logic              clk,
    input  logic              rst,
    imem_load_arb_if.slave    bus
);
    typedef enum logic [1:0] {LOAD = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

    state_t        state, state_nxt;
    logic [AW:0]   ld_cnt_p1;
    logic          ld_err_p1;
    logic          vld_p1;
    logic          misalign_p1;
    logic [31:0]   instr_p1;

    logic          ld_ready;
    logic          core_hold;
    logic          gnt;
    logic          beat;
    logic          load_entry;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          unused_addr_hi;

    // Count stops at 2**AW; the top bit doubles as the "image full" flag.
    function automatic logic [AW:0] sat_inc(input logic [AW:0] c);
        if (c[AW]) return c;
        return c + {{AW{1'b0}}, 1'b1};
    endfunction

    assign beat           = bus.ld_valid_i & ld_ready;
    assign load_entry     = (state != LOAD) && (state_nxt == LOAD);
    assign unused_addr_hi = ^bus.fet_addr_i[31:AW+2];

    always_comb begin
        state_nxt = state;
        ld_ready  = 1'b0;
        core_hold = 1'b1;
        gnt       = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state)
            LOAD: begin
                ld_ready = 1'b1;
                if (bus.ld_valid_i && !ld_cnt_p1[AW]) begin
                    mem_en    = 1'b1;
                    mem_we    = 1'b1;
                    mem_addr  = ld_cnt_p1[AW-1:0];
                    mem_wdata = bus.ld_data_i;
                end
                if (bus.ld_valid_i && bus.ld_last_i) state_nxt = RUN;
            end
            RUN: begin
                core_hold = 1'b0;
                gnt       = bus.fet_req_i;
                if (bus.fet_req_i) begin
                    mem_en   = 1'b1;
                    mem_addr = bus.fet_addr_i[AW+1:2];
                end
                // A fetch granted alongside the reload must still see its data returned.
                if (bus.ld_start_i) state_nxt = bus.fet_req_i ? DRAIN : LOAD;
            end
            DRAIN: state_nxt = LOAD;
            default: state_nxt = LOAD;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= LOAD;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ld_cnt_p1 <= '0;
            ld_err_p1 <= 1'b0;
        end else if (load_entry) begin
            ld_cnt_p1 <= '0;
            ld_err_p1 <= 1'b0;
        end else if (beat) begin
            if (ld_cnt_p1[AW]) ld_err_p1 <= 1'b1;
            ld_cnt_p1 <= sat_inc(ld_cnt_p1);
        end
    end

    // Stage p1: SRAM read data returns; the held copy keeps fet_instr_o stable between reads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1      <= 1'b0;
            misalign_p1 <= 1'b0;
            instr_p1    <= RESET_INSTR;
        end else begin
            vld_p1      <= gnt;
            misalign_p1 <= gnt & (|bus.fet_addr_i[1:0]);
            if (vld_p1) instr_p1 <= bus.mem_rdata_i;
        end
    end

    assign bus.fet_gnt_o      = gnt;
    assign bus.fet_rvalid_o   = vld_p1;
    assign bus.fet_instr_o    = vld_p1 ? bus.mem_rdata_i : instr_p1;
    assign bus.fet_misalign_o = misalign_p1;
    assign bus.ld_ready_o     = ld_ready;
    assign bus.ld_count_o     = ld_cnt_p1;
    assign bus.ld_err_o       = ld_err_p1;
    assign bus.core_hold_o    = core_hold;
    assign bus.mem_en_o       = mem_en;
    assign bus.mem_we_o       = mem_we;
    assign bus.mem_addr_o     = mem_addr;
    assign bus.mem_wdata_o    = mem_wdata;
endmodule

// File: tb/tb_imem_load_arb.sv
// Bench for imem_load_arb: SRAM model, loader/fetch drivers and a fetch-return scoreboard.
`timescale 1ns/1ps
module tb_imem_load_arb;
    localparam int AW = 10;

    logic clk = 1'b0;
    logic rst;

    imem_load_arb_if #(.AW(AW)) bus();

    imem_load_arb #(.AW(AW), .RESET_INSTR(32'h0000_0013)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [31:0] sram    [1024];
    logic [31:0] ref_mem [1024];
    logic [32:0] sb [$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          exp_cnt = 0;
    logic        exp_err = 1'b0;

    always @(posedge clk) begin
        if (bus.mem_en_o && bus.mem_we_o) sram[bus.mem_addr_o] <= bus.mem_wdata_o;
        if (bus.mem_en_o && !bus.mem_we_o) bus.mem_rdata_i <= sram[bus.mem_addr_o];
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.fet_rvalid_o) begin
            check("rvalid_expected", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                logic [32:0] e;
                e = sb.pop_front();
                check("fet_instr", bus.fet_instr_o, e[31:0]);
                check("fet_misalign", bus.fet_misalign_o, e[32]);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_beat(input logic [31:0] d, input logic last);
        bus.ld_valid_i = 1'b1;
        bus.ld_data_i  = d;
        bus.ld_last_i  = last;
        #1;
        check("ld_ready", bus.ld_ready_o, 1);
        if (exp_cnt < 1024) begin
            check("wr_en_we", {bus.mem_en_o, bus.mem_we_o}, 2'b11);
            check("wr_addr", bus.mem_addr_o, exp_cnt);
            check("wr_data", bus.mem_wdata_o, d);
            ref_mem[exp_cnt] = d;
            exp_cnt++;
        end else begin
            check("wr_blocked", {bus.mem_en_o, bus.mem_we_o}, 2'b00);
            exp_err = 1'b1;
        end
        step();
        bus.ld_valid_i = 1'b0;
        bus.ld_last_i  = 1'b0;
        check("ld_count", bus.ld_count_o, exp_cnt);
        check("ld_err", bus.ld_err_o, exp_err);
    endtask

    task automatic fetch(input logic [31:0] a);
        logic [9:0] w;
        w = a[11:2];
        bus.fet_req_i  = 1'b1;
        bus.fet_addr_i = a;
        #1;
        check("fet_gnt", bus.fet_gnt_o, 1);
        check("rd_en_we", {bus.mem_en_o, bus.mem_we_o}, 2'b10);
        check("rd_addr", bus.mem_addr_o, w);
        sb.push_back({(a[1:0] != 2'b00), ref_mem[w]});
        step();
        check("rvalid_after_gnt", bus.fet_rvalid_o, 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst            = 1'b1;
        bus.fet_req_i  = 1'b1;
        bus.fet_addr_i = '0;
        bus.ld_start_i = 1'b0;
        bus.ld_valid_i = 1'b0;
        bus.ld_data_i  = '0;
        bus.ld_last_i  = 1'b0;
        #12;
        check("rst_hold", bus.core_hold_o, 1);
        check("rst_ld_ready", bus.ld_ready_o, 1);
        check("rst_gnt", bus.fet_gnt_o, 0);
        check("rst_count", bus.ld_count_o, 0);
        check("rst_err", bus.ld_err_o, 0);
        check("rst_rvalid", bus.fet_rvalid_o, 0);
        check("rst_instr", bus.fet_instr_o, 32'h13);
        check("rst_mem_en", bus.mem_en_o, 0);
        bus.fet_req_i = 1'b0;
        #5 rst = 1'b0;
        step();

        // Initial 4-word image.
        load_beat(32'h11, 1'b0);
        load_beat(32'h22, 1'b0);
        load_beat(32'h33, 1'b0);
        load_beat(32'h44, 1'b1);
        check("run_hold", bus.core_hold_o, 0);
        check("run_ld_ready", bus.ld_ready_o, 0);

        fetch(32'h0);
        fetch(32'h4);
        fetch(32'h8);
        bus.fet_req_i = 1'b0;
        step();
        check("instr_held", bus.fet_instr_o, 32'h33);

        fetch(32'h1006);
        bus.fet_req_i = 1'b0;

        // Reload requested alongside a fetch: fetch completes in DRAIN.
        bus.ld_start_i = 1'b1;
        fetch(32'hC);
        bus.ld_start_i = 1'b0;
        check("drain_hold", bus.core_hold_o, 1);
        #1;
        check("drain_gnt", bus.fet_gnt_o, 0);
        check("drain_mem_en", bus.mem_en_o, 0);
        bus.fet_req_i = 1'b0;
        step();
        exp_cnt = 0;
        exp_err = 1'b0;
        check("reload_ready", bus.ld_ready_o, 1);
        check("reload_count", bus.ld_count_o, 0);
        check("reload_hold", bus.core_hold_o, 1);
        check("reload_rvalid", bus.fet_rvalid_o, 0);
        check("reload_instr_held", bus.fet_instr_o, 32'h44);

        // Overflowing image: 1025 beats without last, then one with last.
        for (int i = 0; i < 1025; i++) load_beat(32'hA500_0000 ^ (i * 32'h9E37), 1'b0);
        load_beat(32'hDEAD_BEEF, 1'b1);
        check("ovf_hold", bus.core_hold_o, 0);
        check("ovf_count", bus.ld_count_o, 1024);
        check("ovf_err", bus.ld_err_o, 1);
        fetch(32'hFFC);
        fetch(32'h2);
        bus.fet_req_i = 1'b0;
        step();

        // Reload with no fetch pending goes straight to LOAD and clears the error.
        bus.ld_start_i = 1'b1;
        #1;
        check("direct_gnt", bus.fet_gnt_o, 0);
        step();
        bus.ld_start_i = 1'b0;
        exp_cnt = 0;
        exp_err = 1'b0;
        check("direct_ready", bus.ld_ready_o, 1);
        check("direct_count", bus.ld_count_o, 0);
        check("direct_err", bus.ld_err_o, 0);
        check("direct_hold", bus.core_hold_o, 1);

        // Reset in the middle of a 5-beat load.
        load_beat(32'h5555_0001, 1'b0);
        load_beat(32'h5555_0002, 1'b0);
        bus.ld_valid_i = 1'b1;
        bus.ld_data_i  = 32'h5555_0003;
        #1 rst = 1'b1;
        #1;
        check("mid_rst_count", bus.ld_count_o, 0);
        check("mid_rst_err", bus.ld_err_o, 0);
        check("mid_rst_hold", bus.core_hold_o, 1);
        check("mid_rst_ready", bus.ld_ready_o, 1);
        check("mid_rst_rvalid", bus.fet_rvalid_o, 0);
        check("mid_rst_instr", bus.fet_instr_o, 32'h13);
        bus.ld_valid_i = 1'b0;
        step();
        #2 rst = 1'b0;
        step();
        check("post_rst_ready", bus.ld_ready_o, 1);
        check("post_rst_hold", bus.core_hold_o, 1);
        check("post_rst_count", bus.ld_count_o, 0);
        check("sb_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
